// File: rtl/ofs_pcie_rd_cpl_tracker.sv
// ofs_pcie_rd_cpl_tracker
//
// Tracks FPGA->host read requests from tag allocation to their final
// completion. Each request takes the lowest free tag and records the number
// of bytes it expects back. Each completion subtracts its payload bytes from
// that count. When the count is used up, the tag is freed and a one-cycle
// done pulse reports it.
//
// This block assumes completions arrive in order for each tag, meaning the
// PCIe SS does not reorder them. All completion decisions use the state at
// the start of the cycle. As a result:
//   - a tag granted this cycle cannot also be completed this cycle;
//   - a tag freed this cycle cannot be granted again until the next cycle.

module ofs_pcie_rd_cpl_tracker #(
    parameter int MAX_TAGS         = 256,
    parameter int MAX_RD_REQ_BYTES = 512,
    localparam int TAG_W           = $clog2(MAX_TAGS),
    localparam int LEN_W           = $clog2(MAX_RD_REQ_BYTES) + 1
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               alloc_valid,
    input  logic [LEN_W-1:0]   alloc_len,
    output logic               alloc_ready,
    output logic [TAG_W-1:0]   alloc_tag,

    input  logic               cpl_valid,
    input  logic [TAG_W-1:0]   cpl_tag,
    input  logic [LEN_W-1:0]   cpl_bytes,
    output logic               cpl_done_valid,
    output logic [TAG_W-1:0]   cpl_done_tag,

    output logic [TAG_W:0]     in_flight,

    input  logic               err_clear,
    output logic               err_unexp_cpl,
    output logic               err_overrun,
    output logic               err_bad_len
);

    localparam logic [LEN_W-1:0] MAX_LEN   = LEN_W'(MAX_RD_REQ_BYTES);
    localparam logic [TAG_W:0]   TAG_COUNT = (TAG_W+1)'(MAX_TAGS);

    // Tag state: the busy bitmap and the bytes still expected for each tag.
    // remaining_q has no reset because its contents only matter while the
    // matching busy bit is set.
    logic [MAX_TAGS-1:0] busy_q, busy_d;
    logic [LEN_W-1:0]    remaining_q [MAX_TAGS];
    logic [LEN_W-1:0]    remaining_d [MAX_TAGS];

    logic                cpl_done_valid_q, cpl_done_valid_d;
    logic [TAG_W-1:0]    cpl_done_tag_q, cpl_done_tag_d;
    logic [TAG_W:0]      in_flight_q, in_flight_d;
    logic                err_unexp_cpl_q, err_unexp_cpl_d;
    logic                err_overrun_q, err_overrun_d;
    logic                err_bad_len_q, err_bad_len_d;

    logic                free_found;
    logic [TAG_W-1:0]    free_tag;

    logic                alloc_fire;
    logic                alloc_len_bad;
    logic [LEN_W-1:0]    alloc_load;

    logic                cpl_tag_in_range;
    logic                cpl_busy;
    logic [LEN_W-1:0]    cpl_rem;
    logic                cpl_free;
    logic                cpl_partial;
    logic                cpl_over;

    // Lowest-index free tag, taken from the registered bitmap. The loop scans
    // from the top down, so the last match it finds is the lowest index.
    always_comb begin
        free_found = 1'b0;
        free_tag   = '0;
        for (int i = MAX_TAGS - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_found = 1'b1;
                free_tag   = TAG_W'(i);
            end
        end
    end

    // Allocation handshake. A bad length is still granted, but its expected
    // byte count is set to the largest legal request so the tag can drain.
    always_comb begin
        alloc_fire    = alloc_valid & free_found;
        alloc_len_bad = (alloc_len == '0) || (alloc_len > MAX_LEN);
        alloc_load    = alloc_len_bad ? MAX_LEN : alloc_len;
    end

    // Classify the incoming completion against start-of-cycle tag state.
    // A tag index beyond MAX_TAGS (only possible when MAX_TAGS is not a power
    // of two) is treated as not busy.
    always_comb begin
        cpl_tag_in_range = ({1'b0, cpl_tag} < TAG_COUNT);
        cpl_busy         = cpl_valid & cpl_tag_in_range & busy_q[cpl_tag];
        cpl_rem          = remaining_q[cpl_tag];
        cpl_free         = cpl_busy & (cpl_bytes >= cpl_rem);
        cpl_over         = cpl_busy & (cpl_bytes >  cpl_rem);
        cpl_partial      = cpl_busy & (cpl_bytes <  cpl_rem);
    end

    // Next-state logic for the bitmap and the remaining-byte counters. An
    // allocation and a completion in the same cycle can never target the same
    // tag: the granted tag is free, and the completed tag is busy.
    always_comb begin
        busy_d      = busy_q;
        remaining_d = remaining_q;
        if (alloc_fire) begin
            busy_d[free_tag]      = 1'b1;
            remaining_d[free_tag] = alloc_load;
        end
        if (cpl_free) begin
            busy_d[cpl_tag] = 1'b0;
        end
        if (cpl_partial) begin
            remaining_d[cpl_tag] = cpl_rem - cpl_bytes;
        end
    end

    // Count of busy tags. It cannot wrap: an allocation needs a free tag, and
    // a free needs a busy tag.
    always_comb begin
        in_flight_d = in_flight_q;
        unique case ({alloc_fire, cpl_free})
            2'b10:   in_flight_d = in_flight_q + 1'b1;
            2'b01:   in_flight_d = in_flight_q - 1'b1;
            default: in_flight_d = in_flight_q;
        endcase
    end

    // Done pulse, registered one cycle after the freeing completion. The tag
    // output holds its last value while no pulse is active.
    always_comb begin
        cpl_done_valid_d = cpl_free;
        cpl_done_tag_d   = cpl_free ? cpl_tag : cpl_done_tag_q;
    end

    // Sticky error flags. A new error in the same cycle as err_clear wins
    // over the clear.
    always_comb begin
        err_unexp_cpl_d = (cpl_valid & ~cpl_busy)   | (err_unexp_cpl_q & ~err_clear);
        err_overrun_d   = cpl_over                  | (err_overrun_q   & ~err_clear);
        err_bad_len_d   = (alloc_fire & alloc_len_bad) | (err_bad_len_q & ~err_clear);
    end

    // Control and status registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q           <= '0;
            in_flight_q      <= '0;
            cpl_done_valid_q <= 1'b0;
            cpl_done_tag_q   <= '0;
            err_unexp_cpl_q  <= 1'b0;
            err_overrun_q    <= 1'b0;
            err_bad_len_q    <= 1'b0;
        end else begin
            busy_q           <= busy_d;
            in_flight_q      <= in_flight_d;
            cpl_done_valid_q <= cpl_done_valid_d;
            cpl_done_tag_q   <= cpl_done_tag_d;
            err_unexp_cpl_q  <= err_unexp_cpl_d;
            err_overrun_q    <= err_overrun_d;
            err_bad_len_q    <= err_bad_len_d;
        end
    end

    // Remaining-byte storage. It is not reset, so it can map to plain flops
    // or a register array.
    always_ff @(posedge clk) begin
        remaining_q <= remaining_d;
    end

    assign alloc_ready    = free_found;
    assign alloc_tag      = free_tag;
    assign cpl_done_valid = cpl_done_valid_q;
    assign cpl_done_tag   = cpl_done_tag_q;
    assign in_flight      = in_flight_q;
    assign err_unexp_cpl  = err_unexp_cpl_q;
    assign err_overrun    = err_overrun_q;
    assign err_bad_len    = err_bad_len_q;

endmodule
